// File: rtl/id_ex_stage_reg.sv
//------------------------------------------------------------------------------
// Module   : id_ex_stage_reg
// Purpose  : ID->EX pipeline register with stall, flush, bubble insertion and
//            load-use hazard detection. Optional bubble counter: IDEX_PERF_CNT_EN.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,

  input  logic              ex_hold,
  input  logic              flush,
  output logic              hazard_stall,

  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [5:0]        ex_funct,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [5:0]        r_funct;
  logic [1:0]        r_alu_op;
  logic              r_alu_src;
  logic              r_reg_dst;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_reg_write;
  logic              r_mem_to_reg;

  logic              w_rt_nonzero;
  logic              w_src_match;
  logic              w_hazard;
  logic              w_bubble;

  // rt is always treated as a source, so stores and R-types both stall.
  assign w_rt_nonzero = (r_rt != '0);
  assign w_src_match  = (r_rt == id_rs) | (r_rt == id_rt);
  assign w_hazard     = id_valid & r_valid & r_mem_read & w_rt_nonzero
                        & w_src_match & ~flush;
  assign w_bubble     = flush | w_hazard | ~id_valid;

  assign hazard_stall = w_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_funct  <= '0;
    end else if (!ex_hold) begin
      r_rd1    <= id_rd1;
      r_rd2    <= id_rd2;
      r_imm    <= id_imm;
      r_rs     <= id_rs;
      r_rt     <= id_rt;
      r_rd     <= id_rd;
      r_funct  <= id_funct;
    end
  end

  // Bubble entries keep the data path loaded but zero every control bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!ex_hold) begin
      if (w_bubble) begin
        r_valid      <= 1'b0;
        r_alu_op     <= '0;
        r_alu_src    <= 1'b0;
        r_reg_dst    <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
      end else begin
        r_valid      <= 1'b1;
        r_alu_op     <= id_alu_op;
        r_alu_src    <= id_alu_src;
        r_reg_dst    <= id_reg_dst;
        r_mem_read   <= id_mem_read;
        r_mem_write  <= id_mem_write;
        r_reg_write  <= id_reg_write;
        r_mem_to_reg <= id_mem_to_reg;
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_rd1        = r_rd1;
  assign ex_rd2        = r_rd2;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_funct      = r_funct;
  assign ex_alu_op     = r_alu_op;
  assign ex_alu_src    = r_alu_src;
  assign ex_reg_dst    = r_reg_dst;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_to_reg = r_mem_to_reg;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  // Only load-use bubbles are counted; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!ex_hold && w_hazard && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_id_ex_stage_reg
// Purpose  : directed self-checking bench for id_ex_stage_reg.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [5:0]        id_funct;
  logic [1:0]        id_alu_op;
  logic              id_alu_src, id_reg_dst, id_mem_read, id_mem_write;
  logic              id_reg_write, id_mem_to_reg;
  logic              ex_hold, flush;
  logic              hazard_stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_funct;
  logic [1:0]        ex_alu_op;
  logic              ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write;
  logic              ex_reg_write, ex_mem_to_reg;
`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  id_ex_stage_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .ex_hold(ex_hold), .flush(flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef IDEX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction; unlisted control bits use fixed nonzero values.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rd1,
                       input logic mr, input logic rw);
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
    id_rd1        = rd1;
    id_rd2        = ~rd1;
    id_imm        = rd1 ^ 32'hFFFF_0000;
    id_funct      = 6'h20;
    id_alu_op     = 2'b10;
    id_alu_src    = 1'b1;
    id_reg_dst    = 1'b1;
    id_mem_read   = mr;
    id_mem_write  = 1'b0;
    id_reg_write  = rw;
    id_mem_to_reg = mr;
    #1;
  endtask

  task automatic test_reset();
    logic [DATA_W*3+REG_AW*3+6+2+7-1:0] all_out;
    rst_n = 1'b1; ex_hold = 1'b0; flush = 1'b0;
    drive(1'b1, 5'd3, 5'd4, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1);
    id_mem_write = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    all_out = {ex_valid, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
               ex_alu_op, ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_mem_to_reg};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL reset_hazard: got %b want 0", hazard_stall);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", bubble_cnt);
    end
`endif
    #1 rst_n = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h0000_1234, 1'b0, 1'b1);
    id_mem_write = 1'b0;
    step();
    checks++;
    if (ex_rd1 !== 32'h1234 || ex_valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_capture: got rd1=%h v=%b want 1234 v=1", ex_rd1, ex_valid);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd2, 5'd8, 5'd0, 32'h1111_0000, 1'b1, 1'b1);
    step();
    checks++;
    if (ex_mem_read !== 1'b1 || ex_rt !== 5'd8 || ex_mem_to_reg !== 1'b1) begin
      errors++; $display("FAIL lu_lw_capture: got mr=%b rt=%0d want mr=1 rt=8", ex_mem_read, ex_rt);
    end
    drive(1'b1, 5'd8, 5'd3, 5'd9, 32'h2222_0000, 1'b0, 1'b1);
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++; $display("FAIL lu_hazard: got %b want 1", hazard_stall);
    end
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 2'b00 ||
        ex_reg_dst !== 1'b0 || ex_alu_src !== 1'b0 || hazard_stall !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got v=%b rw=%b op=%b hz=%b want all 0",
                         ex_valid, ex_reg_write, ex_alu_op, hazard_stall);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 2'd1) begin
      errors++; $display("FAIL lu_cnt: got %0d want 1", bubble_cnt);
    end
`endif
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_rd1 !== 32'h2222_0000 || ex_alu_op !== 2'b10) begin
      errors++; $display("FAIL lu_replay: got v=%b rs=%0d rd1=%h want v=1 rs=8 rd1=22220000",
                         ex_valid, ex_rs, ex_rd1);
    end
  endtask

  task automatic test_zero_mismatch();
    drive(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 32'h5, 1'b0, 1'b1);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL zero_reg: got %b want 0", hazard_stall);
    end
    drive(1'b1, 5'd1, 5'd9, 5'd0, 32'h6, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd8, 5'd10, 5'd11, 32'h0000_CAFE, 1'b0, 1'b1);
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL mismatch: got %b want 0", hazard_stall);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd1 !== 32'h0000_CAFE || ex_rt !== 5'd10 || ex_imm !== 32'hFFFF_CAFE) begin
      errors++; $display("FAIL mismatch_capture: got v=%b rd1=%h rt=%0d imm=%h want 1 cafe 10 ffffcafe",
                         ex_valid, ex_rd1, ex_rt, ex_imm);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd2, 5'd8, 5'd0, 32'h7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd8, 5'd8, 5'd12, 32'h8, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++; $display("FAIL flush_hazard: got %b want 0", hazard_stall);
    end
    step();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got v=%b rw=%b mr=%b want 0", ex_valid, ex_reg_write, ex_mem_read);
    end
`ifdef IDEX_PERF_CNT_EN
    checks++;
    if (bubble_cnt !== 2'd1) begin
      errors++; $display("FAIL flush_cnt: got %0d want 1", bubble_cnt);
    end
`endif
    drive(1'b0, 5'd1, 5'd2, 5'd3, 32'h9, 1'b0, 1'b1);
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd1 !== 32'h9) begin
      errors++; $display("FAIL idle_bubble: got v=%b rw=%b rd1=%h want 0 0 9", ex_valid, ex_reg_write, ex_rd1);
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 5'd4, 5'd5, 5'd6, 32'h0000_AAAA, 1'b0, 1'b1);
    step();
    ex_hold = 1'b1;
    flush   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 10), 5'd7, 5'd1, 32'h100 + 32'(i), 1'b1, 1'b0);
      step();
      checks++;
      if (ex_rd1 !== 32'h0000_AAAA || ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_rs !== 5'd4) begin
        errors++; $display("FAIL hold_frozen%0d: got rd1=%h v=%b rw=%b rs=%0d want aaaa 1 1 4",
                           i, ex_rd1, ex_valid, ex_reg_write, ex_rs);
      end
    end
    ex_hold = 1'b0;
    flush   = 1'b0;
    drive(1'b1, 5'd13, 5'd14, 5'd15, 32'h0000_BBBB, 1'b0, 1'b1);
    step();
    checks++;
    if (ex_rd1 !== 32'h0000_BBBB || ex_valid !== 1'b1 || ex_rd !== 5'd15) begin
      errors++; $display("FAIL hold_release: got rd1=%h v=%b rd=%0d want bbbb 1 15", ex_rd1, ex_valid, ex_rd);
    end
    ex_hold = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_rd1 !== '0) begin
      errors++; $display("FAIL hold_reset: got v=%b rd1=%h want 0 0", ex_valid, ex_rd1);
    end
    #1 rst_n = 1'b1;
    ex_hold = 1'b0;
  endtask

  task automatic test_saturation();
`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] exp;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 5'd1, 5'd8, 5'd0, 32'h0, 1'b1, 1'b1);
      step();
      drive(1'b1, 5'd8, 5'd2, 5'd3, 32'h1, 1'b0, 1'b1);
      step();
      exp = (k >= 3) ? 2'd3 : 2'(k);
      checks++;
      if (bubble_cnt !== exp) begin
        errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, bubble_cnt, exp);
      end
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    test_reset();
    test_load_use();
    test_zero_mismatch();
    test_flush();
    test_hold();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Parametrised ID→EX pipeline register for the 5-stage MIPS core, generalising the fixed 32-bit stage register with stall, flush and bubble insertion. Captures register-file operands, immediate, register specifiers, funct and control bits each cycle, and tracks a per-entry valid bit. Contains the load-use hazard detector: it stalls the front end and inserts one bubble when the EX-stage load's destination matches an ID-stage source.

## Interface
Parameters:
- DATA_W, 32, width of operand and immediate fields
- REG_AW, 5, register-specifier width
- CNT_W, 16, bubble-counter width (used only with IDEX_PERF_CNT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a live instruction
- id_rd1, id_rd2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  in  REG_AW  register specifiers
- id_funct  in  6  function code
- id_alu_op  in  2; id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  control bits
- ex_hold  in  1  downstream stall; freeze this register
- flush  in  1  kill the ID-stage instruction (taken branch/jump)
- hazard_stall  out  1  combinational; freeze PC and IF/ID
- ex_valid  out  1  EX entry is live
- ex_rd1, ex_rd2, ex_imm  out  DATA_W; ex_rs, ex_rt, ex_rd  out  REG_AW; ex_funct  out  6
- ex_alu_op  out  2; ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each
- bubble_cnt  out  CNT_W  load-use bubble count (macro only)

## Operation
- hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)) & !flush. Conservative: rt always treated as a source. Independent of ex_hold.
- Per-edge priority, highest first:
  1. ex_hold=1: every register holds; flush and hazard are ignored for the update. Upstream keeps flush asserted until the hold releases.
  2. flush=1, hazard_stall=1 or id_valid=0: load a bubble. ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst and ex_alu_op all go to 0. Data, specifier and funct fields still capture their ID inputs; they are don't-care.
  3. Otherwise: capture all ID inputs; ex_valid <= 1.
- A load-use stall lasts exactly one cycle: the bubble clears ex_mem_read, so hazard_stall drops.
- ex_rt = 0 never triggers a stall ($zero).

## Timing
- Latency 1 cycle, ID inputs to ex_* outputs.
- hazard_stall is a same-cycle combinational function of the ID inputs and registered EX state; there is no clock-to-out on it.
- rst_n low asynchronously clears every output register, including ex_valid and bubble_cnt, to 0. Reset mid-hold discards the held entry.
- After rst_n deasserts, the first rising edge captures normally.

## Configuration
- IDEX_PERF_CNT_EN defined:
  - bubble_cnt increments on each edge that loads a bubble because hazard_stall=1 and ex_hold=0.
  - Saturates at 2^CNT_W-1. Flush bubbles and id_valid=0 bubbles are not counted.
- IDEX_PERF_CNT_EN undefined: the bubble_cnt port and counter are absent.

## Test plan
- Reset: drive all inputs nonzero, pulse rst_n low between edges -> all outputs 0 immediately. Release, id_valid=1, id_rd1=0x1234 -> ex_rd1=0x1234 and ex_valid=1 next edge.
- Load-use: EX holds lw with rt=8 (ex_mem_read=1); ID has rs=8 -> hazard_stall=1 same cycle. Next edge: bubble (ex_valid=0, ex_reg_write=0), hazard_stall=0; bubble_cnt=1 with macro.
- $zero and mismatch: EX lw with rt=0 and ID rs=0 -> hazard_stall=0. EX lw rt=9 and ID rs=8, rt=10 -> hazard_stall=0, normal capture.
- Flush: flush=1 with a load-use match present -> hazard_stall=0, bubble loaded, bubble_cnt unchanged.
- Hold: ex_hold=1 for 3 cycles with changing inputs and flush=1 -> outputs frozen. Release with flush=0 -> new ID values captured.
- Saturation (CNT_W=2, macro on): 5 consecutive load-use bubbles -> bubble_cnt=3.
